qam_frame_ctrl: RTL and testbench
=================================

Name: qam_frame_ctrl

Overview:
Frame-level sequencer placed upstream of the QAM modulator top.
- On `start`, it emits PREAMBLE_WORDS fixed preamble words at BPSK, then one header word at QPSK, then `cfg_len` payload words at the configured order.
- Each 32-bit word is handed to the modulator over valid/ready with its mode select, and the select is held stable per word.
- The modulator's QAM order therefore only changes on word boundaries and is under frame control.

Parameters:
- PREAMBLE_WORDS, 2, number of preamble words (legal range 1..15).
- PREAMBLE_PATTERN, 32'hAAAA_AAAA, preamble word value.
- LEN_W, 8, payload length counter width (legal range 1..16).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  frame request; sampled only in IDLE.
- cfg_len  in  LEN_W  payload word count; latched on start.
- cfg_qam  in  3  payload order (0 BPSK, 1 QPSK, 2 16-QAM); latched on start.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle pulse at frame end.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- pl_data  in  32  payload word.
- pl_valid  in  1  payload word available.
- pl_ready  out  1  payload word consumed this cycle.
- mod_data  out  32  word to modulator.
- mod_qam  out  3  order for mod_data.
- mod_valid  out  1  mod_data/mod_qam valid.
- mod_ready  in  1  modulator accepts the word.

Behaviour:
- Reset (rst=0 at posedge):
  - state is IDLE.
  - mod_valid, done, cfg_err, busy are 0.
  - mod_data and mod_qam are 0; counters are 0.
  - Reset mid-frame aborts silently: no done pulse, and the partial frame is discarded.
- Output register:
  - `load_ok = !mod_valid || mod_ready`.
  - mod_data and mod_qam change only on a load.
  - While mod_valid && !mod_ready they hold stable.
  - If load_ok and no word is loaded, mod_valid goes to 0 next cycle.
- States: IDLE, PRE, PAY, DRAIN.
- IDLE:
  - start with cfg_qam<=2: latch cfg, load PATTERN with qam=0 (mod_valid=1 next cycle), pre_cnt=1, go to PRE.
  - start with cfg_qam>2: cfg_err=1 for one cycle, stay in IDLE, no load.
- PRE, on load_ok:
  - If pre_cnt<PREAMBLE_WORDS: load PATTERN with qam=0, pre_cnt++.
  - Otherwise: load header with qam=1. Header is {8'hA5, 5'b0, cfg_qam, cfg_len zero-extended to 16}.
  - After the header load: if cfg_len==0 go to DRAIN, else go to PAY with pay_cnt=0.
- PAY:
  - `pl_ready = load_ok && pl_valid` (combinational; depends on mod_ready).
  - On pl_ready: load pl_data with the latched qam, pay_cnt++.
  - After the load where pay_cnt becomes cfg_len, go to DRAIN.
  - pl_valid=0 creates bubbles only; pl_data is never sampled without pl_valid.
- DRAIN: on mod_valid && mod_ready, set mod_valid=0, pulse done=1 the next cycle, return to IDLE.
- pl_ready is 0 in every state except PAY.
- start while busy is ignored: no cfg_err, and the latched cfg is unchanged.
- start in the cycle done is high is accepted; it is back-to-back legal.
- Latency:
  - start to first mod_valid is 1 cycle.
  - With mod_ready and pl_valid held 1, the frame is PREAMBLE_WORDS+1+cfg_len consecutive cycles of mod_valid.
  - done follows 1 cycle after the final handshake.
- Widths: pre_cnt is 4 bits; pay_cnt is LEN_W bits; comparisons are unsigned with no wrap, since the count stops at cfg_len.

Decomposition:
- Shared package qam_pkg holds:
  - the order constants QAM_BPSK=0, QAM_QPSK=1, QAM_16=2 and QAM_MAX=2;
  - the header sync HDR_SYNC=8'hA5;
  - the state encoding.
- No sub-module; the output register and FSM stay in one module.

Test Plan:
- Reset: rst=0 for 2 cycles with random inputs -> mod_valid, busy, done, cfg_err and pl_ready are all 0.
- Nominal frame: defaults, cfg_len=3, cfg_qam=2, mod_ready=pl_valid=1, payload 11111111/22222222/33333333 -> the sequence below, then done pulses once and exactly 3 pl_ready cycles occur.
  - AAAAAAAA/q0, AAAAAAAA/q0.
  - A5020003/q1.
  - 11111111/q2, 22222222/q2, 33333333/q2.
- Backpressure: mod_ready random 50%, pl_valid random, start pulsed during the frame -> identical word/qam order; mod_data and mod_qam stable whenever valid&&!ready; mid-frame start is ignored.
- Empty payload: cfg_len=0, cfg_qam=1 -> AAAAAAAA/q0 x2, then A5010000/q1, then done; pl_ready never 1.
- Bad config: cfg_qam=3 with start -> cfg_err pulses 1 cycle, busy stays 0, mod_valid stays 0.
- Reset mid-payload: rst=0 for one cycle after the 2nd payload word -> mod_valid=0 and busy=0 next cycle with no done; the next start begins with AAAAAAAA/q0.

Source files
------------

// File: rtl/qam_pkg.sv
// Shared constants and state encoding for the QAM frame sequencer.
package qam_pkg;

    localparam logic [2:0] QAM_BPSK = 3'd0;
    localparam logic [2:0] QAM_QPSK = 3'd1;
    localparam logic [2:0] QAM_16   = 3'd2;
    localparam logic [2:0] QAM_MAX  = 3'd2;

    localparam logic [7:0] HDR_SYNC = 8'hA5;

    typedef enum logic [1:0] {
        StIdle,
        StPre,
        StPay,
        StDrain
    } frame_state_e;

    function automatic logic [31:0] make_header(input logic [2:0]  qam,
                                                input logic [15:0] len);
        return {HDR_SYNC, 5'b0, qam, len};
    endfunction

endpackage

// File: rtl/qam_frame_ctrl.sv
// Frame sequencer: preamble (BPSK), header (QPSK), then payload at the latched order,
// handed to the modulator one word at a time over valid/ready.
module qam_frame_ctrl
    import qam_pkg::*;
#(
    parameter int unsigned PREAMBLE_WORDS   = 2,
    parameter logic [31:0] PREAMBLE_PATTERN = 32'hAAAA_AAAA,
    parameter int unsigned LEN_W            = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic [2:0]       cfg_qam_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             cfg_err_o,
    input  logic [31:0]      pl_data_i,
    input  logic             pl_valid_i,
    output logic             pl_ready_o,
    output logic [31:0]      mod_data_o,
    output logic [2:0]       mod_qam_o,
    output logic             mod_valid_o,
    input  logic             mod_ready_i
);

    localparam logic [3:0] PreWords = 4'(PREAMBLE_WORDS);

    frame_state_e     state_q, state_d;
    logic [3:0]       pre_cnt_q, pre_cnt_d;
    logic [LEN_W-1:0] pay_cnt_q, pay_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [2:0]       qam_q, qam_d;
    logic [31:0]      mod_data_q, mod_data_d;
    logic [2:0]       mod_qam_q, mod_qam_d;
    logic             mod_valid_q, mod_valid_d;
    logic             done_q, done_d;
    logic             cfg_err_q, cfg_err_d;

    logic             load_ok;
    logic             load;
    logic [31:0]      load_data;
    logic [2:0]       load_qam;
    logic             pl_ready;
    logic [15:0]      len_ext;

    assign load_ok = !mod_valid_q || mod_ready_i;
    assign len_ext = 16'(len_q);

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        pay_cnt_d = pay_cnt_q;
        len_d     = len_q;
        qam_d     = qam_q;
        load      = 1'b0;
        load_data = '0;
        load_qam  = QAM_BPSK;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        pl_ready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (cfg_qam_i <= QAM_MAX) begin
                        len_d     = cfg_len_i;
                        qam_d     = cfg_qam_i;
                        load      = 1'b1;
                        load_data = PREAMBLE_PATTERN;
                        load_qam  = QAM_BPSK;
                        pre_cnt_d = 4'd1;
                        pay_cnt_d = '0;
                        state_d   = StPre;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StPre: begin
                if (load_ok) begin
                    load = 1'b1;
                    if (pre_cnt_q < PreWords) begin
                        load_data = PREAMBLE_PATTERN;
                        load_qam  = QAM_BPSK;
                        pre_cnt_d = pre_cnt_q + 4'd1;
                    end else begin
                        load_data = make_header(qam_q, len_ext);
                        load_qam  = QAM_QPSK;
                        pay_cnt_d = '0;
                        state_d   = (len_q == '0) ? StDrain : StPay;
                    end
                end
            end
            StPay: begin
                pl_ready = load_ok && pl_valid_i;
                if (pl_ready) begin
                    load      = 1'b1;
                    load_data = pl_data_i;
                    load_qam  = qam_q;
                    pay_cnt_d = pay_cnt_q + LEN_W'(1);
                    if (pay_cnt_d == len_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Last word still sits in the output register until the modulator takes it.
                if (mod_valid_q && mod_ready_i) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            mod_valid_d = 1'b1;
        end else if (load_ok) begin
            mod_valid_d = 1'b0;
        end else begin
            mod_valid_d = mod_valid_q;
        end
        mod_data_d = load ? load_data : mod_data_q;
        mod_qam_d  = load ? load_qam  : mod_qam_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            pre_cnt_q   <= '0;
            pay_cnt_q   <= '0;
            len_q       <= '0;
            qam_q       <= '0;
            mod_data_q  <= '0;
            mod_qam_q   <= '0;
            mod_valid_q <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            pay_cnt_q   <= pay_cnt_d;
            len_q       <= len_d;
            qam_q       <= qam_d;
            mod_data_q  <= mod_data_d;
            mod_qam_q   <= mod_qam_d;
            mod_valid_q <= mod_valid_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign cfg_err_o   = cfg_err_q;
    assign pl_ready_o  = pl_ready;
    assign mod_data_o  = mod_data_q;
    assign mod_qam_o   = mod_qam_q;
    assign mod_valid_o = mod_valid_q;

endmodule

// File: tb/tb_qam_frame_ctrl.sv
// Randomized self-checking bench for qam_frame_ctrl against a frame-level word-list model.
module tb_qam_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg_len = '0;
    logic [2:0]  cfg_qam = '0;
    logic        busy, done, cfg_err;
    logic [31:0] pl_data = '0;
    logic        pl_valid = 1'b0;
    logic        pl_ready;
    logic [31:0] mod_data;
    logic [2:0]  mod_qam;
    logic        mod_valid;
    logic        mod_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] pay_words[$];
    logic [31:0] exp_data[$];
    logic [2:0]  exp_qam[$];
    logic [31:0] obs_data[$];
    logic [2:0]  obs_qam[$];
    int pl_ready_cnt, done_cnt, stab_err, bad_ready, cfg_err_cnt;
    int first_valid_cyc, last_hs_cyc, done_cyc, valid_cyc_cnt;
    bit timed_out;

    qam_frame_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .cfg_len_i  (cfg_len),
        .cfg_qam_i  (cfg_qam),
        .busy_o     (busy),
        .done_o     (done),
        .cfg_err_o  (cfg_err),
        .pl_data_i  (pl_data),
        .pl_valid_i (pl_valid),
        .pl_ready_o (pl_ready),
        .mod_data_o (mod_data),
        .mod_qam_o  (mod_qam),
        .mod_valid_o(mod_valid),
        .mod_ready_i(mod_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Frame model: 2 preamble words, header, then the offered payload in order.
    function automatic void build_expected(input int len, input logic [2:0] qam);
        exp_data.delete();
        exp_qam.delete();
        for (int i = 0; i < 2; i++) begin
            exp_data.push_back(32'hAAAA_AAAA);
            exp_qam.push_back(3'd0);
        end
        exp_data.push_back(32'hA500_0000 | (32'(qam) << 16) | 32'(len));
        exp_qam.push_back(3'd1);
        for (int i = 0; i < len; i++) begin
            exp_data.push_back(pay_words[i]);
            exp_qam.push_back(qam);
        end
    endfunction

    task automatic run_frame(input int len, input logic [2:0] qam, input bit rand_ready,
                             input bit rand_valid, input bit poke);
        int idx = 0;
        int cyc = 0;
        logic prev_stall = 1'b0;
        logic [31:0] prev_d = '0;
        logic [2:0] prev_q = '0;
        obs_data.delete();
        obs_qam.delete();
        pl_ready_cnt = 0; done_cnt = 0; stab_err = 0; bad_ready = 0; cfg_err_cnt = 0;
        first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1; valid_cyc_cnt = 0;
        timed_out = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc == 0) begin
                start = 1'b1; cfg_len = len[7:0]; cfg_qam = qam;
            end else if (poke && busy && ($urandom % 4 == 0)) begin
                start = 1'b1; cfg_len = 8'($urandom); cfg_qam = 3'($urandom_range(0, 3));
            end else begin
                start = 1'b0;
            end
            mod_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
            pl_valid  = (idx < pay_words.size()) && (rand_valid ? ($urandom % 3 != 0) : 1'b1);
            pl_data   = pl_valid ? pay_words[idx] : $urandom;
            #1;
            if (mod_valid) begin
                valid_cyc_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (prev_stall && (mod_data !== prev_d || mod_qam !== prev_q)) stab_err++;
                if (mod_ready) begin
                    obs_data.push_back(mod_data);
                    obs_qam.push_back(mod_qam);
                    last_hs_cyc = cyc;
                end
            end
            prev_stall = mod_valid && !mod_ready;
            prev_d = mod_data;
            prev_q = mod_qam;
            if (pl_ready) begin
                pl_ready_cnt++;
                if (!pl_valid) bad_ready++;
                else idx++;
            end
            if (cfg_err) cfg_err_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            cyc++;
            if (cyc > 3000) begin
                timed_out = 1'b1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'($urandom); cfg_len = 8'($urandom); cfg_qam = 3'($urandom);
            pl_valid = 1'($urandom); pl_data = $urandom; mod_ready = 1'($urandom);
        end
        @(negedge clk);
        #1;
        n_checks++; if (mod_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mod_valid: got %b expected 0", mod_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
        n_checks++; if (pl_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pl_ready: got %b expected 0", pl_ready); end
        n_checks++; if (mod_data !== 32'h0 || mod_qam !== 3'h0) begin n_fail++; $display("FAIL reset_mod_regs: got %h/%0d expected 0/0", mod_data, mod_qam); end
        start = 1'b0; pl_valid = 1'b0; mod_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_frame(input string name, input int len);
        n_checks++; if (timed_out) begin n_fail++; $display("FAIL %s_timeout: got timeout expected done", name); end
        n_checks++; if (obs_data.size() != exp_data.size()) begin n_fail++; $display("FAIL %s_word_count: got %0d expected %0d", name, obs_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size(); i++) begin
            n_checks++;
            if (i >= obs_data.size()) begin
                n_fail++; $display("FAIL %s_word%0d: got none expected %h/q%0d", name, i, exp_data[i], exp_qam[i]);
            end else if (obs_data[i] !== exp_data[i] || obs_qam[i] !== exp_qam[i]) begin
                n_fail++; $display("FAIL %s_word%0d: got %h/q%0d expected %h/q%0d", name, i, obs_data[i], obs_qam[i], exp_data[i], exp_qam[i]);
            end
        end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL %s_done_count: got %0d expected 1", name, done_cnt); end
        n_checks++; if (done_cyc != last_hs_cyc + 1) begin n_fail++; $display("FAIL %s_done_timing: got cycle %0d expected %0d", name, done_cyc, last_hs_cyc + 1); end
        n_checks++; if (pl_ready_cnt != len) begin n_fail++; $display("FAIL %s_pl_ready_count: got %0d expected %0d", name, pl_ready_cnt, len); end
        n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL %s_stall_stability: got %0d changes expected 0", name, stab_err); end
        n_checks++; if (bad_ready != 0) begin n_fail++; $display("FAIL %s_ready_without_valid: got %0d expected 0", name, bad_ready); end
        n_checks++; if (cfg_err_cnt != 0) begin n_fail++; $display("FAIL %s_cfg_err: got %0d expected 0", name, cfg_err_cnt); end
    endtask

    task automatic test_nominal();
        pay_words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        build_expected(3, 3'd2);
        run_frame(3, 3'd2, 1'b0, 1'b0, 1'b0);
        check_frame("nominal", 3);
        n_checks++; if (first_valid_cyc != 1) begin n_fail++; $display("FAIL nominal_start_latency: got %0d expected 1", first_valid_cyc); end
        n_checks++; if (valid_cyc_cnt != 6 || last_hs_cyc - first_valid_cyc != 5) begin n_fail++; $display("FAIL nominal_consecutive: got %0d valid cycles span %0d expected 6 span 5", valid_cyc_cnt, last_hs_cyc - first_valid_cyc); end
    endtask

    task automatic test_backpressure();
        for (int it = 0; it < 3; it++) begin
            int len = $urandom_range(4, 10);
            logic [2:0] qam = 3'($urandom_range(0, 2));
            pay_words.delete();
            for (int i = 0; i < len; i++) pay_words.push_back($urandom);
            build_expected(len, qam);
            run_frame(len, qam, 1'b1, 1'b1, 1'b1);
            check_frame("backpressure", len);
        end
    endtask

    task automatic test_empty_payload();
        pay_words.delete();
        build_expected(0, 3'd1);
        run_frame(0, 3'd1, 1'b0, 1'b1, 1'b0);
        check_frame("empty", 0);
    endtask

    task automatic test_bad_config();
        int err_cnt = 0, busy_cnt = 0, valid_cnt = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            start = (cyc == 0); cfg_qam = 3'd3; cfg_len = 8'($urandom); mod_ready = 1'b1;
            #1;
            if (cfg_err) err_cnt++;
            if (busy) busy_cnt++;
            if (mod_valid) valid_cnt++;
        end
        start = 1'b0;
        n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL badcfg_cfg_err_pulse: got %0d cycles expected 1", err_cnt); end
        n_checks++; if (busy_cnt != 0) begin n_fail++; $display("FAIL badcfg_busy: got %0d cycles expected 0", busy_cnt); end
        n_checks++; if (valid_cnt != 0) begin n_fail++; $display("FAIL badcfg_mod_valid: got %0d cycles expected 0", valid_cnt); end
    endtask

    task automatic test_reset_mid_payload();
        int hs = 0, cyc = 0, done_seen = 0;
        pay_words = '{32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003, 32'hCAFE_0004};
        while (hs < 5 && cyc < 200) begin
            @(negedge clk);
            start = (cyc == 0); cfg_len = 8'd4; cfg_qam = 3'd2;
            mod_ready = 1'b1; pl_valid = 1'b1; pl_data = pay_words[(hs > 2) ? hs - 3 : 0];
            #1;
            if (mod_valid && mod_ready) hs++;
            cyc++;
        end
        n_checks++; if (hs != 5) begin n_fail++; $display("FAIL midreset_reach: got %0d handshakes expected 5", hs); end
        @(negedge clk);
        start = 1'b0; pl_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (mod_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_clear: got valid=%b busy=%b expected 0/0", mod_valid, busy); end
        for (int i = 0; i < 4; i++) begin
            if (done) done_seen++;
            @(negedge clk);
            #1;
        end
        n_checks++; if (done_seen != 0) begin n_fail++; $display("FAIL midreset_done: got %0d pulses expected 0", done_seen); end
        pay_words = '{32'h0BAD_F00D};
        build_expected(1, 3'd0);
        run_frame(1, 3'd0, 1'b0, 1'b0, 1'b0);
        check_frame("after_reset", 1);
    endtask

    task automatic test_back_to_back();
        int cyc = 0, hs = 0;
        logic [31:0] third = '0;
        bit got_done = 1'b0;
        while (!got_done && cyc < 100) begin
            @(negedge clk);
            start = (cyc == 0); cfg_len = 8'd1; cfg_qam = 3'd0;
            mod_ready = 1'b1; pl_valid = 1'b1; pl_data = 32'h5555_0000;
            #1;
            if (done) begin
                got_done = 1'b1;
                start = 1'b1; cfg_len = 8'd0; cfg_qam = 3'd2;
            end
            cyc++;
        end
        n_checks++; if (!got_done) begin n_fail++; $display("FAIL b2b_first_done: got none expected pulse"); end
        @(negedge clk);
        start = 1'b0; pl_valid = 1'b0;
        #1;
        n_checks++; if (mod_valid !== 1'b1 || busy !== 1'b1 || mod_data !== 32'hAAAA_AAAA || mod_qam !== 3'd0) begin
            n_fail++; $display("FAIL b2b_restart: got v=%b busy=%b %h/q%0d expected 1 1 aaaaaaaa/q0", mod_valid, busy, mod_data, mod_qam);
        end
        got_done = 1'b0;
        for (int i = 0; i < 20 && !got_done; i++) begin
            if (mod_valid && mod_ready) begin
                hs++;
                if (hs == 3) third = mod_data;
            end
            @(negedge clk);
            #1;
            if (done) got_done = 1'b1;
        end
        n_checks++; if (!got_done || hs != 3) begin n_fail++; $display("FAIL b2b_second_frame: got done=%b words=%0d expected 1/3", got_done, hs); end
        n_checks++; if (third !== 32'hA502_0000) begin n_fail++; $display("FAIL b2b_header: got %h expected a5020000", third); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_empty_payload();
        test_bad_config();
        test_reset_mid_payload();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
